// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage: retires instructions, waits for load data,
// aligns/extends it and drives the register-file write port for one cycle.
module writeback_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_result,
  input  logic                  load_data_valid,
  input  logic [XLEN-1:0]       load_data,
  output logic [REG_ADDR_W-1:0] register_write,
  output logic [XLEN-1:0]       write_data,
  output logic                  register_write_enable,
  output logic                  retire,
  output logic                  misaligned_fault,
  output logic                  pending_load_valid,
  output logic [REG_ADDR_W-1:0] pending_load_rd
);

  typedef enum logic [1:0] {StIdle, StWaitLoad, StCommit} state_e;

  state_e                r_state, w_state_d;
  logic [REG_ADDR_W-1:0] r_rd, w_rd_d;
  logic                  r_reg_write, w_reg_write_d;
  logic [2:0]            r_funct3, w_funct3_d;
  logic [1:0]            r_addr, w_addr_d;
  logic [REG_ADDR_W-1:0] r_wr_rd, w_wr_rd_d;
  logic [XLEN-1:0]       r_wr_data, w_wr_data_d;
  logic                  r_we, w_we_d;
  logic                  r_retire, w_retire_d;
  logic                  r_fault, w_fault_d;

  logic                  w_accept;
  logic                  w_in_fault;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load_value;

  assign in_ready = (r_state != StWaitLoad);
  assign w_accept = in_valid && in_ready;

  // Illegal funct3 or a misaligned halfword/word access.
  always_comb begin
    w_in_fault = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: w_in_fault = 1'b0;
      3'b001, 3'b101: w_in_fault = in_result[0];
      3'b010:         w_in_fault = |in_result[1:0];
      default:        w_in_fault = 1'b1;
    endcase
    w_in_fault = w_in_fault && in_is_load;
  end

  always_comb begin
    w_byte = load_data[7:0];
    case (r_addr)
      2'd0:    w_byte = load_data[7:0];
      2'd1:    w_byte = load_data[15:8];
      2'd2:    w_byte = load_data[23:16];
      default: w_byte = load_data[31:24];
    endcase
    w_half = r_addr[1] ? load_data[31:16] : load_data[15:0];
    case (r_funct3)
      3'b000:  w_load_value = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_value = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_value = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_value = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_value = load_data;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_rd_d        = r_rd;
    w_reg_write_d = r_reg_write;
    w_funct3_d    = r_funct3;
    w_addr_d      = r_addr;
    w_wr_rd_d     = r_wr_rd;
    w_wr_data_d   = r_wr_data;
    w_we_d        = 1'b0;
    w_retire_d    = 1'b0;
    w_fault_d     = 1'b0;
    case (r_state)
      StWaitLoad: begin
        if (load_data_valid) begin
          w_state_d   = StCommit;
          w_we_d      = r_reg_write && (r_rd != '0);
          w_retire_d  = 1'b1;
          w_wr_rd_d   = r_rd;
          w_wr_data_d = w_load_value;
        end
      end
      default: begin
        if (w_accept) begin
          w_rd_d        = in_rd;
          w_reg_write_d = in_reg_write;
          w_funct3_d    = in_funct3;
          w_addr_d      = in_result[1:0];
          if (in_is_load && !w_in_fault) begin
            // Write port keeps its previous values while the load is outstanding.
            w_state_d = StWaitLoad;
          end else begin
            w_state_d   = StCommit;
            w_we_d      = in_reg_write && (in_rd != '0) && !w_in_fault;
            w_retire_d  = 1'b1;
            w_fault_d   = w_in_fault;
            w_wr_rd_d   = in_rd;
            w_wr_data_d = in_result;
          end
        end else begin
          w_state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wr_rd     <= '0;
      r_wr_data   <= '0;
      r_we        <= 1'b0;
      r_retire    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rd        <= w_rd_d;
      r_reg_write <= w_reg_write_d;
      r_funct3    <= w_funct3_d;
      r_addr      <= w_addr_d;
      r_wr_rd     <= w_wr_rd_d;
      r_wr_data   <= w_wr_data_d;
      r_we        <= w_we_d;
      r_retire    <= w_retire_d;
      r_fault     <= w_fault_d;
    end
  end

  assign register_write        = r_wr_rd;
  assign write_data            = r_wr_data;
  assign register_write_enable = r_we;
  assign retire                = r_retire;
  assign misaligned_fault      = r_fault;
  assign pending_load_valid    = (r_state == StWaitLoad) && r_reg_write && (r_rd != '0);
  assign pending_load_rd       = r_rd;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases then random traffic
// compared against a transaction-level model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        load_data_valid;
  logic [31:0] load_data;
  logic [4:0]  register_write;
  logic [31:0] write_data;
  logic        register_write_enable;
  logic        retire;
  logic        misaligned_fault;
  logic        pending_load_valid;
  logic [4:0]  pending_load_rd;

  int n_err = 0;
  int n_chk = 0;

  // Model state: outstanding load and the expected commit for the coming cycle.
  bit          m_wait = 0;
  logic [4:0]  m_rd = '0;
  bit          m_rw = 0;
  logic [2:0]  m_f3 = '0;
  logic [31:0] m_addr = '0;
  bit          e_we, e_ret, e_flt;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_rd                 (in_rd),
    .in_reg_write          (in_reg_write),
    .in_is_load            (in_is_load),
    .in_funct3             (in_funct3),
    .in_result             (in_result),
    .load_data_valid       (load_data_valid),
    .load_data             (load_data),
    .register_write        (register_write),
    .write_data            (write_data),
    .register_write_enable (register_write_enable),
    .retire                (retire),
    .misaligned_fault      (misaligned_fault),
    .pending_load_valid    (pending_load_valid),
    .pending_load_rd       (pending_load_rd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_fault(input bit ld, input logic [2:0] f3, input logic [31:0] addr);
    if (!ld) return 0;
    case (f3)
      3'd0, 3'd4: return 0;
      3'd1, 3'd5: return (addr % 2) != 0;
      3'd2:       return (addr % 4) != 0;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data);
    logic [31:0] v;
    int          off;
    off = int'(addr % 4);
    v   = data >> (8 * off);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
      3'd5: v = v & 32'hFFFF;
      default: v = data;
    endcase
    return v;
  endfunction

  task automatic step(input bit v, input bit ld, input logic [2:0] f3, input logic [4:0] rd,
                      input bit rw, input logic [31:0] res, input bit ldv,
                      input logic [31:0] ldd, input bit rst);
    bit flt;
    bit pv;
    in_valid = v; in_is_load = ld; in_funct3 = f3; in_rd = rd; in_reg_write = rw;
    in_result = res; load_data_valid = ldv; load_data = ldd; reset = rst;
    @(negedge clk);
    pv = m_wait && m_rw && (m_rd != 0);
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, !m_wait});
    check_eq("pend_valid", {31'd0, pending_load_valid}, {31'd0, pv});
    if (pv) check_eq("pend_rd", {27'd0, pending_load_rd}, {27'd0, m_rd});
    @(posedge clk);
    e_we = 0; e_ret = 0; e_flt = 0;
    if (rst) begin
      m_wait = 0;
    end else if (m_wait) begin
      if (ldv) begin
        m_wait = 0;
        e_ret  = 1;
        e_we   = m_rw && (m_rd != 0);
        e_rd   = m_rd;
        e_data = load_value(m_f3, m_addr, ldd);
      end
    end else if (v) begin
      flt = is_fault(ld, f3, res);
      if (ld && !flt) begin
        m_wait = 1; m_rd = rd; m_rw = rw; m_f3 = f3; m_addr = res;
      end else begin
        e_ret  = 1;
        e_flt  = flt;
        e_we   = rw && (rd != 0) && !flt;
        e_rd   = rd;
        e_data = res;
      end
    end
    #1;
    check_eq("we", {31'd0, register_write_enable}, {31'd0, e_we});
    check_eq("retire", {31'd0, retire}, {31'd0, e_ret});
    check_eq("fault", {31'd0, misaligned_fault}, {31'd0, e_flt});
    if (e_we) begin
      check_eq("wr_rd", {27'd0, register_write}, {27'd0, e_rd});
      check_eq("wr_data", write_data, e_data);
    end
  endtask

  task automatic idle(input bit ldv, input logic [31:0] ldd);
    step(0, 0, 3'd0, 5'd0, 0, 32'd0, ldv, ldd, 0);
  endtask

  initial begin
    step(0, 0, 3'd0, 5'd0, 0, 32'd0, 0, 32'd0, 1);
    step(0, 0, 3'd0, 5'd0, 0, 32'd0, 0, 32'd0, 1);
    check_eq("rst_wr_rd", {27'd0, register_write}, 32'd0);
    check_eq("rst_wr_data", write_data, 32'd0);
    check_eq("rst_pend_rd", {27'd0, pending_load_rd}, 32'd0);

    // Plain ALU op.
    step(1, 0, 3'd0, 5'd5, 1, 32'h1234_5678, 0, 32'd0, 0);
    check_eq("alu_we", {31'd0, register_write_enable}, 32'd1);
    check_eq("alu_data", write_data, 32'h1234_5678);
    idle(0, 32'd0);
    check_eq("alu_we_off", {31'd0, register_write_enable}, 32'd0);

    // LB at offset 3 with three idle wait cycles.
    step(1, 1, 3'd0, 5'd7, 1, 32'h0000_1003, 0, 32'd0, 0);
    repeat (3) idle(0, 32'd0);
    check_eq("lb_ready", {31'd0, in_ready}, 32'd0);
    check_eq("lb_pend_rd", {27'd0, pending_load_rd}, 32'd7);
    idle(1, 32'h80FF_0000);
    check_eq("lb_data", write_data, 32'hFFFF_FF80);

    step(1, 1, 3'd5, 5'd9, 1, 32'h0000_2002, 0, 32'd0, 0);
    idle(1, 32'hBEEF_0001);
    check_eq("lhu_data", write_data, 32'h0000_BEEF);
    step(1, 1, 3'd1, 5'd9, 1, 32'h0000_2002, 0, 32'd0, 0);
    idle(1, 32'hBEEF_0001);
    check_eq("lh_data", write_data, 32'hFFFF_BEEF);

    // Misaligned LW and illegal funct3 commit immediately as faults.
    step(1, 1, 3'd2, 5'd4, 1, 32'h0000_3001, 0, 32'd0, 0);
    check_eq("lw_fault", {31'd0, misaligned_fault}, 32'd1);
    check_eq("lw_ready", {31'd0, in_ready}, 32'd1);
    step(1, 1, 3'd3, 5'd4, 1, 32'h0000_3000, 0, 32'd0, 0);
    check_eq("f3_fault", {31'd0, misaligned_fault}, 32'd1);

    // Back-to-back ALU ops.
    step(1, 0, 3'd0, 5'd1, 1, 32'h11, 0, 32'd0, 0);
    step(1, 0, 3'd0, 5'd2, 1, 32'h22, 0, 32'd0, 0);
    check_eq("b2b_data2", write_data, 32'h22);
    step(1, 0, 3'd0, 5'd0, 1, 32'h33, 0, 32'd0, 0);
    check_eq("b2b_we_rd0", {31'd0, register_write_enable}, 32'd0);
    check_eq("b2b_retire", {31'd0, retire}, 32'd1);
    idle(0, 32'd0);

    // Reset while a load waits; the late response must be dropped.
    step(1, 1, 3'd4, 5'd12, 1, 32'h0000_0040, 0, 32'd0, 0);
    step(0, 0, 3'd0, 5'd0, 0, 32'd0, 0, 32'd0, 1);
    idle(1, 32'hDEAD_BEEF);
    check_eq("rst_drop_ret", {31'd0, retire}, 32'd0);
    check_eq("rst_drop_pend", {31'd0, pending_load_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r_addr;
      logic [2:0]  r_f3;
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'(($urandom_range(0, 1)) * 2);
      r_f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                         : 3'(($urandom_range(0, 2) == 2) ? 2 :
                                              ($urandom_range(0, 1) * 4 + $urandom_range(0, 1)));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, r_f3, 5'($urandom),
           $urandom_range(0, 7) != 0, r_addr, $urandom_range(0, 9) < 4, $urandom,
           $urandom_range(0, 49) == 0);
    end

    // Drain: at most one response completes any outstanding load.
    idle(1, 32'h0F0F_F0F0);
    repeat (3) idle(0, 32'd0);
    check_eq("drain_ready", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
